// File: rtl/sig_merge_pkg.sv
// Shared constants and types for the two-channel signal merger.
package sig_merge_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 2;
    localparam int CNT_W     = 16;

    typedef logic [0:0] ch_id_t;

endpackage

// File: rtl/sig_merge_fifo.sv
// Per-channel buffer: DEPTH-entry FIFO with count register and wrapping pointers.
// Latency: a pushed word is visible on o_dat the cycle after the push.
// Backpressure: o_full raises at DEPTH entries; pushes while full and pops while empty are ignored.
module sig_merge_fifo
    import sig_merge_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic [DW-1:0] i_dat,
    input  logic          i_pop,
    output logic [DW-1:0] o_dat,
    output logic          o_empty,
    output logic          o_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign o_empty = (cnt_q == '0);
    assign o_full  = (cnt_q == CNT_MAX);
    assign o_dat   = mem_q[rd_ptr_q];
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = i_dat;
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/sig_merge_arb.sv
// Merges two valid/ready channels into one registered, source-tagged stream with round-robin grant.
// Latency: a word accepted in cycle N reaches o_sig_vld in N+2 at the earliest; 1 word/cycle sustained.
// Backpressure: output register holds while i_sig_rdy=0; o_sig_rdyN drops when its buffer is full.
// SIG_MERGE_CNT_EN adds 16-bit per-channel grant counters on o_cnt0/o_cnt1.
module sig_merge_arb
    import sig_merge_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sig_vld0,
    input  logic [DW-1:0]    i_sig_dat0,
    output logic             o_sig_rdy0,
    input  logic             i_sig_vld1,
    input  logic [DW-1:0]    i_sig_dat1,
    output logic             o_sig_rdy1,
    output logic             o_sig_vld,
    output logic [DW-1:0]    o_sig_dat,
    output logic             o_sig_src,
    input  logic             i_sig_rdy
`ifdef SIG_MERGE_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
`endif
);

    logic          rdy_en_q, rdy_en_d;
    ch_id_t        ptr_q, ptr_d;
    logic          vld_q, vld_d;
    logic [DW-1:0] dat_q, dat_d;
    ch_id_t        src_q, src_d;

    logic [DW-1:0] f_dat0, f_dat1;
    logic          f_empty0, f_empty1, f_full0, f_full1;
    logic          push0, push1, pop0, pop1;
    logic          load_en, gnt_vld;
    ch_id_t        gnt;

    // rdy_en_q keeps ready low through reset and for the first cycle after it, from a flop only.
    assign o_sig_rdy0 = rdy_en_q && !f_full0;
    assign o_sig_rdy1 = rdy_en_q && !f_full1;
    assign push0      = i_sig_vld0 && o_sig_rdy0;
    assign push1      = i_sig_vld1 && o_sig_rdy1;
    assign load_en    = !vld_q || i_sig_rdy;

    sig_merge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (push0),
        .i_dat  (i_sig_dat0),
        .i_pop  (pop0),
        .o_dat  (f_dat0),
        .o_empty(f_empty0),
        .o_full (f_full0)
    );

    sig_merge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo1 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_push (push1),
        .i_dat  (i_sig_dat1),
        .i_pop  (pop1),
        .o_dat  (f_dat1),
        .o_empty(f_empty1),
        .o_full (f_full1)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = ptr_q;
        if (load_en) begin
            if (!f_empty0 && !f_empty1) begin
                gnt_vld = 1'b1;
                gnt     = ptr_q;
            end else if (!f_empty0) begin
                gnt_vld = 1'b1;
                gnt     = 1'b0;
            end else if (!f_empty1) begin
                gnt_vld = 1'b1;
                gnt     = 1'b1;
            end
        end
    end

    assign pop0 = gnt_vld && (gnt == 1'b0);
    assign pop1 = gnt_vld && (gnt == 1'b1);

    always_comb begin
        rdy_en_d = 1'b1;
        ptr_d    = ptr_q;
        vld_d    = vld_q;
        dat_d    = dat_q;
        src_d    = src_q;
        if (load_en) begin
            vld_d = gnt_vld;
            if (gnt_vld) begin
                dat_d = (gnt == 1'b1) ? f_dat1 : f_dat0;
                src_d = gnt;
                ptr_d = ~gnt;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdy_en_q <= 1'b0;
            ptr_q    <= 1'b0;
            vld_q    <= 1'b0;
            dat_q    <= '0;
            src_q    <= 1'b0;
        end else begin
            rdy_en_q <= rdy_en_d;
            ptr_q    <= ptr_d;
            vld_q    <= vld_d;
            dat_q    <= dat_d;
            src_q    <= src_d;
        end
    end

    assign o_sig_vld = vld_q;
    assign o_sig_dat = dat_q;
    assign o_sig_src = src_q;

`ifdef SIG_MERGE_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (pop0) cnt0_d = cnt0_q + CNT_W'(1);
        if (pop1) cnt1_d = cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign o_cnt0 = cnt0_q;
    assign o_cnt1 = cnt1_q;
`endif

endmodule
